// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM state
// encoding and the store-side lane helpers.
package mem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

  // Unknown width codes and misaligned halves/words never reach memory.
  function automatic logic is_illegal(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] lo);
    logic ill;
    ill = 1'b1;
    case (funct3)
      F3_B:    ill = 1'b0;
      F3_H:    ill = lo[0];
      F3_W:    ill = |lo;
      F3_BU:   ill = we;
      F3_HU:   ill = we | lo[0];
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] funct3,
                                            input logic [1:0] lo);
    logic [3:0] mask;
    mask = 4'b0000;
    case (funct3)
      F3_B:    mask = 4'b0001 << lo;
      F3_H:    mask = 4'b0011 << {lo[1], 1'b0};
      F3_W:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0]  funct3,
                                             input logic [31:0] wdata);
    logic [31:0] data;
    data = wdata;
    case (funct3)
      F3_B:    data = {4{wdata[7:0]}};
      F3_H:    data = {2{wdata[15:0]}};
      default: data = wdata;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/mem_lsu_ldalign.sv
// Load lane extraction: selects the addressed byte/half of the memory word
// and sign- or zero-extends it according to the width code.
module mem_lsu_ldalign
  import mem_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [15:0] lane;

  assign lane = 16'(rdata >> {addr, 3'b000});

  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   result = {24'h000000, lane[7:0]};
      F3_H:    result = {{16{lane[15]}}, lane[15:0]};
      F3_HU:   result = {16'h0000, lane[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// RV32I load/store unit for a single-cycle registered-read memory: one
// request in flight, all outputs registered, one-cycle completion pulse.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask
);

  lsu_state_e  state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;

  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        mem_rstrb_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wmask_q;

  logic        req_illegal;
  logic [31:0] ld_result;

  assign req_illegal = is_illegal(req_we, req_funct3, req_addr[1:0]);

  mem_lsu_ldalign u_ldalign (
    .rdata  (mem_rdata),
    .addr   (addr_q[1:0]),
    .funct3 (funct3_q),
    .result (ld_result)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_rstrb_q <= 1'b0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      // NOTE: pulse outputs default low here and are raised only by the branch
      // that needs them; non-blocking keeps every read at pre-edge values.
      rsp_valid_q <= 1'b0;
      mem_rstrb_q <= 1'b0;
      mem_wmask_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            funct3_q    <= req_funct3;
            addr_q      <= req_addr;
            mem_wdata_q <= store_data(req_funct3, req_wdata);
            req_ready_q <= 1'b0;
            if (req_illegal) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q     <= S_ISSUE;
              mem_rstrb_q <= ~req_we;
              mem_wmask_q <= req_we ? store_mask(req_funct3, req_addr[1:0]) : 4'b0000;
            end
          end
        end
        S_ISSUE: begin
          if (we_q) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Memory data registered on the ISSUE->WAIT edge is stable now.
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= ld_result;
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_rstrb = mem_rstrb_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized self-checking bench for mem_lsu: behavioural byte-array model,
// registered-read memory attached directly to the DUT.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;

  mem_lsu dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_rstrb  (mem_rstrb),
    .mem_rdata  (mem_rdata),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask)
  );

  always #5 clk = ~clk;

  // Single-cycle registered-read memory, 256 words, aliased on addr[9:2].
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_rstrb) mem_rdata <= mem[mem_addr[9:2]];
    for (int b = 0; b < 4; b++)
      if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  // Event monitor sampled on the falling edge.
  int          cyc = 0;
  int          rsp_cnt = 0, rstrb_cnt = 0, wmask_cnt = 0, last_rsp_cyc = 0;
  logic [31:0] last_rdata = '0, last_wdata = '0, last_maddr = '0;
  logic        last_err = 1'b0;
  logic [3:0]  last_wmask = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_cnt      <= rsp_cnt + 1;
      last_rsp_cyc <= cyc;
      last_rdata   <= rsp_rdata;
      last_err     <= rsp_err;
    end
    if (mem_rstrb) begin
      rstrb_cnt  <= rstrb_cnt + 1;
      last_maddr <= mem_addr;
    end
    if (mem_wmask != 4'b0000) begin
      wmask_cnt  <= wmask_cnt + 1;
      last_wmask <= mem_wmask;
      last_wdata <= mem_wdata;
      last_maddr <= mem_addr;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: byte-addressed memory image plus width rules.
  logic [7:0] ref_mem [0:1023];

  function automatic int model_size(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_illegal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    bit code_ok;
    code_ok = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!code_ok) return 1'b1;
    return (int'(addr[1:0]) % model_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    int     sz;
    longint v;
    sz = model_size(f3);
    v  = 0;
    for (int i = 0; i < sz; i++) v += longint'(ref_mem[int'(addr[9:0]) + i]) << (8 * i);
    if (!f3[2] && sz < 4 && v >= (64'sd1 << (8 * sz - 1))) v -= (64'sd1 << (8 * sz));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    for (int i = 0; i < model_size(f3); i++) ref_mem[int'(addr[9:0]) + i] = wdata[8*i +: 8];
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          n_rsp;
    int          n_rstrb;
    int          n_wmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] maddr;
    int          waited;
    logic [31:0] hold_rdata;
    logic        hold_err;
  } obs_t;

  // Present a request and return just after the edge that accepts it.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit keep, output int acc, output int waited);
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    waited = 0;
    #1;
    while (!req_ready && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    acc = cyc + 1;
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0;
  endtask

  // Observe the response (bounded), then one more cycle for pulse width / hold.
  task automatic collect(input int acc, inout obs_t o);
    int s_rsp, s_rstrb, s_wmask, w;
    s_rsp = rsp_cnt; s_rstrb = rstrb_cnt; s_wmask = wmask_cnt; w = 0;
    while (rsp_cnt == s_rsp && w < 8) begin
      @(negedge clk); #1;
      w++;
    end
    @(negedge clk); #1;
    o.rdata      = last_rdata;
    o.err        = last_err;
    o.lat        = last_rsp_cyc - acc + 1;
    o.n_rsp      = rsp_cnt - s_rsp;
    o.n_rstrb    = rstrb_cnt - s_rstrb;
    o.n_wmask    = wmask_cnt - s_wmask;
    o.wmask      = last_wmask;
    o.wdata      = last_wdata;
    o.maddr      = last_maddr;
    o.hold_rdata = rsp_rdata;
    o.hold_err   = rsp_err;
  endtask

  task automatic verify(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input obs_t o);
    bit          ill;
    int          sz;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0]  exp_mask;
    ill = model_illegal(we, f3, addr);
    sz  = model_size(f3);
    exp_rd = (ill || we) ? 32'h0 : model_load(f3, addr);
    check("accept_wait", o.waited, 0);
    check("rsp_pulse_count", o.n_rsp, 1);
    check("rsp_err", {31'b0, o.err}, {31'b0, ill});
    check("rsp_rdata", o.rdata, exp_rd);
    check("rsp_hold_rdata", o.hold_rdata, exp_rd);
    check("rsp_hold_err", {31'b0, o.hold_err}, {31'b0, ill});
    check("latency", o.lat, ill ? 1 : (we ? 2 : 3));
    check("rstrb_cycles", o.n_rstrb, (!ill && !we) ? 1 : 0);
    check("wmask_cycles", o.n_wmask, (!ill && we) ? 1 : 0);
    if (!ill) check("mem_addr", o.maddr, {addr[31:2], 2'b00});
    if (!ill && we) begin
      exp_mask = 4'(((1 << sz) - 1) << addr[1:0]);
      for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = wdata[8*(l % sz) +: 8];
      check("wmask", {28'b0, o.wmask}, {28'b0, exp_mask});
      check("wdata", o.wdata, exp_wd);
      model_store(f3, addr, wdata);
    end
  endtask

  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output obs_t o);
    int acc;
    send(we, f3, addr, wdata, 1'b0, acc, o.waited);
    collect(acc, o);
    verify(we, f3, addr, wdata, o);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    obs_t        o;
    int          acc, acc2, w, s;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_mem_rstrb", {31'b0, mem_rstrb}, 32'd0);
    check("rst_mem_wmask", {28'b0, mem_wmask}, 32'd0);
    check("rst_mem_addr",  mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 256; i++) do_txn(1'b1, 3'b010, 32'(i * 4), 32'h0, o);

    // Byte store lane placement
    do_txn(1'b1, 3'b000, 32'h191, 32'h0000_00A5, o);
    check("sb_wmask", {28'b0, o.wmask}, 32'b0010);
    check("sb_wdata", o.wdata, 32'hA5A5_A5A5);
    check("sb_latency", o.lat, 2);

    // Load extension cases
    do_txn(1'b1, 3'b010, 32'h190, 32'h80FF_7F01, o);
    do_txn(1'b0, 3'b000, 32'h192, 32'h0, o);
    check("lb_sext", o.rdata, 32'hFFFF_FFFF);
    do_txn(1'b0, 3'b100, 32'h192, 32'h0, o);
    check("lbu_zext", o.rdata, 32'h0000_00FF);
    do_txn(1'b0, 3'b001, 32'h192, 32'h0, o);
    check("lh_sext", o.rdata, 32'hFFFF_80FF);
    do_txn(1'b0, 3'b010, 32'h190, 32'h0, o);
    check("lw_pass", o.rdata, 32'h80FF_7F01);
    check("lw_latency", o.lat, 3);

    // Misaligned requests
    do_txn(1'b0, 3'b010, 32'h192, 32'h0, o);
    check("lw_mis_err", {31'b0, o.err}, 32'd1);
    check("lw_mis_rstrb", o.n_rstrb, 0);
    check("lw_mis_latency", o.lat, 1);
    do_txn(1'b1, 3'b001, 32'h193, 32'hBEEF, o);
    check("sh_mis_err", {31'b0, o.err}, 32'd1);
    check("sh_mis_wmask", o.n_wmask, 0);

    // Back-to-back with req_valid held high
    send(1'b1, 3'b010, 32'h10, 32'h1234_5678, 1'b1, acc, w);
    model_store(3'b010, 32'h10, 32'h1234_5678);
    send(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, acc2, w);
    collect(acc2, o);
    check("b2b_accept_gap", acc2 - acc, 3);
    check("b2b_rdata", o.rdata, 32'h1234_5678);
    check("b2b_latency", o.lat, 3);

    // Reset during a store's ISSUE cycle
    do_txn(1'b1, 3'b010, 32'h200, 32'hCAFE_F00D, o);
    s = rsp_cnt;
    send(1'b1, 3'b010, 32'h200, 32'h1111_1111, 1'b0, acc, w);
    check("abort_issue_wmask", {28'b0, mem_wmask}, 32'hF);
    resetn = 1'b0;
    #1;
    check("abort_wmask", {28'b0, mem_wmask}, 32'd0);
    check("abort_rstrb", {31'b0, mem_rstrb}, 32'd0);
    check("abort_req_ready", {31'b0, req_ready}, 32'd1);
    check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("abort_no_rsp", rsp_cnt - s, 0);
    // Request waiting as reset releases: accepted on the first rising edge.
    @(negedge clk);
    resetn = 1'b1;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200; req_wdata = 32'h0; req_valid = 1'b1;
    acc = cyc + 1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    collect(acc, o);
    check("post_rst_rdata", o.rdata, 32'hCAFE_F00D);
    check("post_rst_latency", o.lat, 3);
    check("post_rst_pulse", o.n_rsp, 1);

    // Byte loop: stores then readback
    for (int i = 0; i < 17; i++) do_txn(1'b1, 3'b000, 32'(400 + i), 32'(i), o);
    for (int i = 0; i < 17; i++) begin
      do_txn(1'b0, 3'b000, 32'(400 + i), 32'h0, o);
      check("byte_readback", o.rdata, 32'(i));
    end

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_f3    = 3'($urandom_range(0, 7));
      r_addr  = $urandom();
      r_wdata = $urandom();
      if ($urandom_range(0, 2) != 0) r_addr[1:0] = 2'b00;
      do_txn(r_we, r_f3, r_addr, r_wdata, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
